// File: rtl/ram_16x256_pkg.sv
// Shared constants and types for the 256 x 16 sample delay-line RAM.
package ram_16x256_pkg;

    localparam int RAM_DATA_WIDTH = 16;
    localparam int RAM_ADDR_WIDTH = 8;
    localparam int RAM_DEPTH      = 256;

    typedef logic [RAM_DATA_WIDTH-1:0] ram_word_t;
    typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;

endpackage : ram_16x256_pkg

// File: rtl/ram_16x256_array.sv
// Bare storage array: synchronous write port and a registered
// read-before-write read port. There is no reset, so synthesis can map it
// onto block RAM. Contents power up as all zeros.
module ram_16x256_array
    import ram_16x256_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Zero-initialised so the filter's first sweep reads zeros.
    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1] = '{default: {DATA_WIDTH{1'b0}}};
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Write and read share one edge; the read samples the array before the
    // write lands, so a same-address read returns the old word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data_r <= mem_r[rd_addr];
    end

    assign rd_data = rd_data_r;

endmodule : ram_16x256_array

// File: rtl/ram_16x256.sv
// Simple dual-port 256 x 16 RAM used as the decimating FIR's sample delay
// line. Reset clears only the read output; memory contents survive it.
// Optional macro RAM_16X256_OUTREG_EN adds a second output register stage
// (2-cycle read latency); without it the read latency is 1 cycle.
module ram_16x256
    import ram_16x256_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [DATA_WIDTH-1:0] q
);

    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [DATA_WIDTH-1:0] stage1_s;
    logic                  out_en_r;

    // Writes are suppressed for as long as reset is high, including the
    // edge at which reset is first seen.
    assign wr_en_s = wren & ~reset;

    ram_16x256_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clock   (clock),
        .wr_en   (wr_en_s),
        .wr_addr (wraddress),
        .wr_data (data),
        .rd_addr (rdaddress),
        .rd_data (rd_data_s)
    );

    // Output-enable flag: cleared asynchronously by reset, set by the first
    // edge after release, which is the edge that performs the first valid read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_en_r <= 1'b0;
        end else begin
            out_en_r <= 1'b1;
        end
    end

    // The array's read register cannot carry a reset without losing block-RAM
    // inference, so the first output stage is forced to zero by the flag. This
    // makes q drop to zero the moment reset rises.
    assign stage1_s = rd_data_s & {DATA_WIDTH{out_en_r}};

`ifdef RAM_16X256_OUTREG_EN
    logic [DATA_WIDTH-1:0] q_r;

    // Second output stage, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_r <= {DATA_WIDTH{1'b0}};
        end else begin
            q_r <= stage1_s;
        end
    end

    assign q = q_r;
`else
    assign q = stage1_s;
`endif

endmodule : ram_16x256

// File: tb/tb_ram_16x256.sv
// Scoreboard bench for ram_16x256: every stimulus step queues the expected
// read result, and a monitor pops and compares after each clock edge.
module tb_ram_16x256;

`ifdef RAM_16X256_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data = 16'h0000;
    logic [7:0]  wraddress = 8'h00;
    logic        wren = 1'b0;
    logic [7:0]  rdaddress = 8'h00;
    logic [15:0] q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          chk;
        logic [15:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    ram_16x256 dut (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .q         (q)
    );

    always #5 clock = ~clock;

    // Monitor: the read sampled LAT edges ago is visible 1 ns after this edge.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() >= LAT) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    checks++;
                    if (q !== e.exp) begin
                        errors++;
                        $display("FAIL %s: q=0x%04h expected 0x%04h", e.name, q, e.exp);
                    end
                end
            end
        end
    end

    // Direct comparison used around the asynchronous reset.
    task automatic check_now(input string name, input logic [15:0] exp);
        checks++;
        if (q !== exp) begin
            errors++;
            $display("FAIL %s: q=0x%04h expected 0x%04h", name, q, exp);
        end
    endtask

    // One clock step: drive at the falling edge, queue expectation, cross the
    // rising edge, return at the next falling edge.
    task automatic step(input logic we, input logic [7:0] wa, input logic [15:0] wd,
                        input logic [7:0] ra, input bit chk, input logic [15:0] exp,
                        input string name);
        sb_entry_t e;
        wren = we;
        wraddress = wa;
        data = wd;
        rdaddress = ra;
        e.chk = chk;
        e.exp = exp;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        check_now("reset_q", 16'h0000);
        reset = 1'b0;

        // Power-up contents are zero
        step(1'b0, 8'd0, 16'h0000, 8'd0,   1'b1, 16'h0000, "pwrup_0");
        step(1'b0, 8'd0, 16'h0000, 8'd100, 1'b1, 16'h0000, "pwrup_100");
        step(1'b0, 8'd0, 16'h0000, 8'd255, 1'b1, 16'h0000, "pwrup_255");

        // Basic write then read
        step(1'b1, 8'd5, 16'h1234, 8'd0, 1'b0, 16'h0000, "wr5");
        step(1'b0, 8'd0, 16'h0000, 8'd5, 1'b1, 16'h1234, "basic_rd5");

        // Read-during-write returns old data, new data on the next read
        step(1'b1, 8'd7, 16'hAAAA, 8'd0, 1'b0, 16'h0000, "wr7");
        step(1'b1, 8'd7, 16'h5555, 8'd7, 1'b1, 16'hAAAA, "rdw_old");
        step(1'b0, 8'd0, 16'h0000, 8'd7, 1'b1, 16'h5555, "rdw_new");

        // Write enable gating
        step(1'b1, 8'd9, 16'h0001, 8'd0, 1'b0, 16'h0000, "wr9");
        step(1'b0, 8'd9, 16'hFFFF, 8'd0, 1'b0, 16'h0000, "nowr9");
        step(1'b0, 8'd0, 16'h0000, 8'd9, 1'b1, 16'h0001, "wren_gate");

        // Full sweep: value equals address
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'(i), 16'(i), 8'd0, 1'b0, 16'h0000, "sweep_wr");
        end
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 8'd0, 16'h0000, 8'(i), 1'b1, 16'(i), "sweep_rd");
        end

        // Reset mid-operation
        step(1'b1, 8'd5, 16'h1234, 8'd0, 1'b0, 16'h0000, "rewr5");
        step(1'b0, 8'd0, 16'h0000, 8'd5, 1'b1, 16'h1234, "pre_rst_a");
        step(1'b0, 8'd0, 16'h0000, 8'd5, 1'b1, 16'h1234, "pre_rst_b");
        step(1'b0, 8'd0, 16'h0000, 8'd5, 1'b0, 16'h0000, "pre_rst_c");
        #1;
        check_now("pre_rst_q", 16'h1234);
        #1;
        reset = 1'b1;
        wren = 1'b1;
        wraddress = 8'd5;
        data = 16'hDEAD;
        #1;
        check_now("rst_async_q", 16'h0000);
        @(negedge clock);
        step(1'b1, 8'd5, 16'hDEAD, 8'd5, 1'b0, 16'h0000, "in_rst_a");
        #1;
        check_now("rst_hold_q", 16'h0000);
        step(1'b1, 8'd5, 16'hBEEF, 8'd5, 1'b0, 16'h0000, "in_rst_b");
        #1;
        check_now("rst_hold_q2", 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 8'd0, 16'h0000, 8'd5, 1'b1, 16'h1234, "post_rst_rd5");
        step(1'b0, 8'd0, 16'h0000, 8'd255, 1'b1, 16'h00FF, "post_rst_rd255");

        // Flush pipeline
        repeat (3) step(1'b0, 8'd0, 16'h0000, 8'd0, 1'b0, 16'h0000, "flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ram_16x256
